rf_write_voter: RTL
===================

// Module: rf_write_voter
// PURPOSE
//  Parametrised successor to the dual-write comparator between redundant cores and the shared register file.
//  Compares NUM_CH replicated write ports {we, addr, data} every cycle and forwards one registered write.
//  NUM_CH=2 (DMR): any disagreement blocks the write and requests a rollback.
//  NUM_CH=3 (TMR): single-channel faults are masked by majority vote; triple disagreement requests a rollback.
// PARAMETERS
//  NUM_CH  3   redundant channels; legal values 2 or 3 only; any other value -> $fatal at elaboration
//  ADDR_W  5   register address width
//  DATA_W  32  write data width
//  CNT_W   8   error counter width (used only with RFV_ERR_CNT_EN)
// PORTS
//  clk_i           in   1              clock
//  rst_ni          in   1              asynchronous active-low reset
//  we_i            in   NUM_CH         per-channel write enable; ch k = bit k
//  waddr_i         in   NUM_CH*ADDR_W  per-channel address; ch k = [k*ADDR_W +: ADDR_W]
//  wdata_i         in   NUM_CH*DATA_W  per-channel data; ch k = [k*DATA_W +: DATA_W]
//  we_o            out  1              voted write enable to register file
//  waddr_o         out  ADDR_W         voted address
//  wdata_o         out  DATA_W         voted data
//  error_o         out  1              one-cycle pulse: a disagreement was detected
//  faulty_ch_o     out  NUM_CH         minority channel(s) of the last detected error; held until next error/clr
//  sticky_err_o    out  1              set by any error, cleared only by clr_i or reset
//  rollback_req_o  out  1              level request to cores to roll back and re-execute
//  rollback_ack_i  in   1              cores acknowledge rollback
//  clr_i           in   1              synchronous clear of sticky_err_o, faulty_ch_o, err_cnt_o
//  err_cnt_o       out  CNT_W          saturating error count (0 without RFV_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in RUN.
//  - Tuple equality: channels agree iff we equal and (we==0 or (addr equal and data equal)); addr/data are don't-care when we==0.
//  - Latency: 1 cycle; inputs sampled at edge N appear on we_o/waddr_o/wdata_o/error_o after edge N.
//  - FSM states: RUN, ROLLBACK, HOLD.
//  - RUN, all agree: forward ch0 tuple; error_o=0.
//  - RUN, NUM_CH=3, exactly two agree: forward the majority tuple; error_o=1; faulty_ch_o=one-hot minority; stay in RUN.
//  - RUN, NUM_CH=2 mismatch, or NUM_CH=3 all distinct: we_o=0; error_o=1; faulty_ch_o=all ones; next state ROLLBACK.
//  - ROLLBACK: rollback_req_o=1; we_o=0; inputs ignored with no compare and no new errors; ack sampled high -> HOLD.
//  - HOLD: one cycle; we_o=0; rollback_req_o=0; inputs ignored; -> RUN.
//  - Ack seen in RUN or HOLD is ignored.
//  - sticky_err_o is set on any error_o cycle.
//  - clr_i in the same cycle as a new error: clear applies first, then the error is recorded (sticky=1, faulty_ch_o updated, count=1).
//  - Reset asserted mid-ROLLBACK: immediate return to RUN, all outputs 0, pending request dropped.
//  - waddr_o/wdata_o are 0 whenever we_o=0.
// CONFIGURATION
//  RFV_ERR_CNT_EN defined: err_cnt_o increments by 1 on each error_o cycle.
//    It saturates at 2^CNT_W-1 and is cleared by clr_i/reset.
//  RFV_ERR_CNT_EN undefined: no counter is implemented; err_cnt_o is tied to 0.
//  All other behaviour is identical in both configurations.
// TESTING
//  1. NUM_CH=3, all ch {1,5'd3,32'd10}: next cycle we_o=1, waddr_o=3, wdata_o=10, error_o=0.
//  2. NUM_CH=3, ch1 data=11, others 10: forwarded wdata_o=10, error_o pulse.
//     Expect faulty_ch_o=3'b010, sticky_err_o=1, rollback_req_o=0, err_cnt_o=1 (with macro).
//  3. NUM_CH=2, data 10 vs 11: we_o=0, error_o=1, faulty_ch_o=2'b11.
//     rollback_req_o=1 from the next cycle until ack; after ack, one HOLD cycle, then RUN forwards writes.
//  4. NUM_CH=3, we=3'b000 with differing addr/data: no error; we_o=0.
//     Then we=3'b011: error, faulty_ch_o=3'b100, forwarded we_o=1.
//  5. CNT_W=2 with macro: 5 masked errors -> err_cnt_o saturates at 3.
//     clr_i together with a 6th error -> err_cnt_o=1, sticky_err_o=1.
//  6. Assert rst_ni low while in ROLLBACK: all outputs 0 asynchronously.
//     After release: RUN, and a matching write forwards normally.

Source files
------------

// File: rtl/rf_write_voter.sv
// Replicated register-file write voter (DMR compare / TMR majority) with rollback handshake.
// Optional saturating error counter enabled by defining RFV_ERR_CNT_EN.
module rf_write_voter #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH*ADDR_W-1:0] waddr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  output logic                     we_o,
  output logic [ADDR_W-1:0]        waddr_o,
  output logic [DATA_W-1:0]        wdata_o,
  output logic                     error_o,
  output logic [NUM_CH-1:0]        faulty_ch_o,
  output logic                     sticky_err_o,
  output logic                     rollback_req_o,
  input  logic                     rollback_ack_i,
  input  logic                     clr_i,
  output logic [CNT_W-1:0]         err_cnt_o
);
  localparam int SEL_W = $clog2(NUM_CH);

  generate
    if (NUM_CH != 2 && NUM_CH != 3) begin : g_bad_num_ch
      $fatal(1, "rf_write_voter: NUM_CH must be 2 or 3");
    end
  endgenerate

  typedef enum logic [1:0] {RUN, ROLLBACK, HOLD} state_t;
  state_t state;

  logic [NUM_CH-1:0][ADDR_W-1:0] addr_u;
  logic [NUM_CH-1:0][DATA_W-1:0] data_u;
  assign addr_u = waddr_i;
  assign data_u = wdata_i;

  // addr/data only matter when the write is enabled
  function automatic logic teq(input logic wa, input logic [ADDR_W-1:0] aa,
                               input logic [DATA_W-1:0] da, input logic wb,
                               input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
    return (wa == wb) && (!wa || (aa == ab && da == db));
  endfunction

  logic              v_err, v_rb;
  logic [SEL_W-1:0]  v_sel;
  logic [NUM_CH-1:0] v_faulty;

  generate
    if (NUM_CH == 3) begin : g_tmr
      logic eq01, eq02, eq12;
      always_comb begin
        eq01     = teq(we_i[0], addr_u[0], data_u[0], we_i[1], addr_u[1], data_u[1]);
        eq02     = teq(we_i[0], addr_u[0], data_u[0], we_i[2], addr_u[2], data_u[2]);
        eq12     = teq(we_i[1], addr_u[1], data_u[1], we_i[2], addr_u[2], data_u[2]);
        v_sel    = '0;
        v_err    = 1'b0;
        v_rb     = 1'b0;
        v_faulty = '0;
        if (eq01 && eq02) begin
          v_sel = '0;
        end else if (eq01) begin
          v_err = 1'b1; v_faulty = 3'b100;
        end else if (eq02) begin
          v_err = 1'b1; v_faulty = 3'b010;
        end else if (eq12) begin
          v_err = 1'b1; v_faulty = 3'b001; v_sel = SEL_W'(1);
        end else begin
          v_err = 1'b1; v_rb = 1'b1; v_faulty = '1;
        end
      end
    end else begin : g_dmr
      logic eq01;
      always_comb begin
        eq01     = teq(we_i[0], addr_u[0], data_u[0], we_i[1], addr_u[1], data_u[1]);
        v_sel    = '0;
        v_err    = !eq01;
        v_rb     = !eq01;
        v_faulty = eq01 ? '0 : '1;
      end
    end
  endgenerate

  logic              fwd_we;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  assign fwd_we   = !v_rb && we_i[v_sel];
  assign fwd_addr = fwd_we ? addr_u[v_sel] : '0;
  assign fwd_data = fwd_we ? data_u[v_sel] : '0;

  logic new_err;
  assign new_err = (state == RUN) && v_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= RUN;
      we_o           <= 1'b0;
      waddr_o        <= '0;
      wdata_o        <= '0;
      error_o        <= 1'b0;
      faulty_ch_o    <= '0;
      sticky_err_o   <= 1'b0;
      rollback_req_o <= 1'b0;
    end else begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      error_o <= 1'b0;
      // clear first so an error in the same cycle is still recorded
      if (clr_i) begin
        sticky_err_o <= 1'b0;
        faulty_ch_o  <= '0;
      end
      case (state)
        RUN: begin
          we_o    <= fwd_we;
          waddr_o <= fwd_addr;
          wdata_o <= fwd_data;
          if (v_err) begin
            error_o      <= 1'b1;
            sticky_err_o <= 1'b1;
            faulty_ch_o  <= v_faulty;
          end
          if (v_rb) begin
            state          <= ROLLBACK;
            rollback_req_o <= 1'b1;
          end
        end
        ROLLBACK: begin
          if (rollback_ack_i) begin
            state          <= HOLD;
            rollback_req_o <= 1'b0;
          end
        end
        HOLD:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef RFV_ERR_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (new_err) begin
      if (clr_i)                err_cnt_o <= CNT_W'(1);
      else if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
    end else if (clr_i) begin
      err_cnt_o <= '0;
    end
  end
`else
  assign err_cnt_o = '0;
  logic unused_cnt;
  assign unused_cnt = new_err;
`endif
endmodule
